// File: rtl/mcash_xbar_pkg.sv
// Shared cross-bar types and constants.
// Used by the bank arbiter and the return-path mux.
package mcash_xbar_pkg;

    localparam int NUM_CH              = 3;
    localparam int MAX_OUTSTANDING_DEF = 8;
    localparam int ADDR_W_DEF          = 32;
    localparam int ID_W_DEF            = 4;

    typedef logic [1:0] ch_idx_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [ID_W_DEF-1:0]   id;
    } xbar_req_t;

    function automatic ch_idx_t rr_next(input ch_idx_t g);
        return (g == 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin picker.
// Searches ptr, ptr+1, ptr+2 (mod 3); first hit wins.
module rr_arb3
    import mcash_xbar_pkg::*;
(
    input  logic [2:0] req_i,
    input  ch_idx_t    ptr_i,
    output logic [2:0] gnt_o,
    output ch_idx_t    idx_o,
    output logic       any_o
);

    logic [2:0] w_c;

    // Rotate from the pointer and take the first requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        w_c   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_c = {1'b0, ptr_i} + 3'(k);
            if (w_c >= 3'd3) begin
                w_c = w_c - 3'd3;
            end
            if (!any_o && req_i[w_c[1:0]]) begin
                any_o           = 1'b1;
                gnt_o[w_c[1:0]] = 1'b1;
                idx_o           = w_c[1:0];
            end
        end
    end

endmodule

// File: rtl/cross_bar_bank_arb.sv
// Per-bank read-request arbiter: round-robin over 3 channels,
// per-channel credit limit, single registered output slot.
module cross_bar_bank_arb
    import mcash_xbar_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [2:0]            ch_req_valid_i,
    output logic [2:0]            ch_req_allowIn_o,
    input  logic [3*ADDR_W-1:0]   ch_req_addr_i,
    input  logic [3*ID_W-1:0]     ch_req_id_i,
    output logic                  bank_req_valid_o,
    input  logic                  bank_req_allowIn_i,
    output logic [ADDR_W-1:0]     bank_req_addr_o,
    output logic [ID_W-1:0]       bank_req_id_o,
    output logic [1:0]            bank_req_ch_o,
    input  logic [2:0]            ch_rtn_valid_i,
    output logic [3*CNT_W-1:0]    ch_outstanding_o,
    output logic                  err_o
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_st_t;

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OUTSTANDING);

    slot_st_t          r_state;
    ch_idx_t           r_rr_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    ch_idx_t           r_ch;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic              r_err;

    logic              w_slot_free;
    logic [2:0]        w_elig;
    logic [2:0]        w_gnt;
    ch_idx_t           w_idx;
    logic              w_any;
    logic [2:0]        w_kick_vec;
    logic              w_kick;
    logic [ADDR_W-1:0] w_addr [NUM_CH];
    logic [ID_W-1:0]   w_id   [NUM_CH];

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_addr[gi] = ch_req_addr_i[gi*ADDR_W +: ADDR_W];
        assign w_id[gi]   = ch_req_id_i[gi*ID_W +: ID_W];
        assign w_elig[gi] = ch_req_valid_i[gi] & (r_cnt[gi] < LP_MAX);
        assign ch_outstanding_o[gi*CNT_W +: CNT_W] = r_cnt[gi];
    end

    rr_arb3 u_arb (
        .req_i (w_elig),
        .ptr_i (r_rr_ptr),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // The slot can take a new request if empty or draining this cycle.
    assign w_slot_free = (r_state == S_EMPTY) |
                         ((r_state == S_FULL) & bank_req_allowIn_i);

    assign ch_req_allowIn_o = w_gnt & {3{w_slot_free & rst_ni}};
    assign w_kick_vec       = ch_req_valid_i & ch_req_allowIn_o;
    assign w_kick           = w_any & w_slot_free & rst_ni;

    assign bank_req_valid_o = (r_state == S_FULL);
    assign bank_req_addr_o  = r_addr;
    assign bank_req_id_o    = r_id;
    assign bank_req_ch_o    = r_ch;
    assign err_o            = r_err;

    // Output slot FSM: load on kickoff, hold under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_EMPTY;
            r_rr_ptr <= '0;
            r_addr   <= '0;
            r_id     <= '0;
            r_ch     <= '0;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_kick) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (!w_kick && bank_req_allowIn_i) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
            if (w_kick) begin
                r_addr   <= w_addr[w_idx];
                r_id     <= w_id[w_idx];
                r_ch     <= w_idx;
                r_rr_ptr <= rr_next(w_idx);
            end
        end
    end

    // Outstanding credit counters; underflow sets the sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                unique case ({w_kick_vec[i], ch_rtn_valid_i[i]})
                    2'b10: begin
                        if (r_cnt[i] != LP_MAX) begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    2'b01: begin
                        if (r_cnt[i] == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cross_bar_bank_arb.sv
// Scoreboard bench for cross_bar_bank_arb.
// Directed vectors; monitor pops expected bank requests.
module tb_cross_bar_bank_arb;

    logic         clk;
    logic         rst_n;
    logic [2:0]   valid;
    logic [2:0]   allow;
    logic [95:0]  addr_bus;
    logic [11:0]  id_bus;
    logic         bvalid;
    logic         brdy;
    logic [31:0]  baddr;
    logic [3:0]   bid;
    logic [1:0]   bch;
    logic [2:0]   rtn;
    logic [11:0]  outs_bus;
    logic         err;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [1:0]  ch;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    cross_bar_bank_arb dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .ch_req_valid_i     (valid),
        .ch_req_allowIn_o   (allow),
        .ch_req_addr_i      (addr_bus),
        .ch_req_id_i        (id_bus),
        .bank_req_valid_o   (bvalid),
        .bank_req_allowIn_i (brdy),
        .bank_req_addr_o    (baddr),
        .bank_req_id_o      (bid),
        .bank_req_ch_o      (bch),
        .ch_rtn_valid_i     (rtn),
        .ch_outstanding_o   (outs_bus),
        .err_o              (err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] outs(input int i);
        return outs_bus[i*4 +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] a,
                          input logic [3:0] d);
        addr_bus[i*32 +: 32] = a;
        id_bus[i*4 +: 4]     = d;
    endtask

    task automatic push(input int i);
        exp_t e;
        e.addr = addr_bus[i*32 +: 32];
        e.id   = id_bus[i*4 +: 4];
        e.ch   = 2'(i);
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 0;
        valid = 0;
        rtn   = 0;
        brdy  = 1;
        tick();
        tick();
        rst_n = 1;
    endtask

    // Monitor: every accepted bank request must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bvalid && brdy) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected act=%0h/%0h/%0d exp=none",
                         baddr, bid, bch);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (baddr !== e.addr || bid !== e.id || bch !== e.ch) begin
                    bad++;
                    $display("FAIL mon_req act=%0h/%0h/%0d exp=%0h/%0h/%0d",
                             baddr, bid, bch, e.addr, e.id, e.ch);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        addr_bus = '0;
        id_bus   = '0;
        valid    = 0;
        rtn      = 0;
        brdy     = 1;
        rst_n    = 0;
        #1;
        valid = 3'b111;
        #1;
        chk("rst_allow", 32'(allow), 0);
        chk("rst_valid", 32'(bvalid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_outs", 32'(outs_bus), 0);
        chk("rst_addr", baddr, 0);
        do_reset();

        // Single request on ch1
        set_ch(1, 32'h40, 4'd3);
        valid = 3'b010;
        #1;
        chk("single_allow", 32'(allow), 32'b010);
        push(1);
        tick();
        valid = 0;
        chk("single_valid", 32'(bvalid), 1);
        chk("single_ch", 32'(bch), 1);
        chk("single_outs1", 32'(outs(1)), 1);
        tick();
        chk("single_drain", 32'(bvalid), 0);

        // Fairness: order 0,1,2,0,1,2 at 1/cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_ch(i, 32'h1000 + 32'(i), 4'(i + 8));
        end
        valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fair_allow", 32'(allow), 32'(1 << (k % 3)));
            push(k % 3);
            tick();
            chk("fair_valid", 32'(bvalid), 1);
        end
        valid = 0;
        tick();
        chk("fair_outs0", 32'(outs(0)), 2);
        chk("fair_outs2", 32'(outs(2)), 2);

        // Backpressure on a full slot
        do_reset();
        brdy = 0;
        set_ch(0, 32'h100, 4'd1);
        set_ch(1, 32'h200, 4'd2);
        valid = 3'b001;
        #1;
        chk("bp_first_allow", 32'(allow), 32'b001);
        push(0);
        tick();
        valid = 3'b010;
        for (int k = 0; k < 5; k++) begin
            chk("bp_allow", 32'(allow), 0);
            chk("bp_valid", 32'(bvalid), 1);
            chk("bp_addr", baddr, 32'h100);
            chk("bp_ch", 32'(bch), 0);
            tick();
        end
        brdy = 1;
        #1;
        chk("bp_release_allow", 32'(allow), 32'b010);
        push(1);
        tick();
        valid = 0;
        tick();

        // Credit limit on ch2
        do_reset();
        set_ch(0, 32'h500, 4'd6);
        set_ch(1, 32'h600, 4'd7);
        set_ch(2, 32'h300, 4'd5);
        valid = 3'b100;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("cred_allow", 32'(allow), 32'b100);
            push(2);
            tick();
        end
        chk("cred_outs_full", 32'(outs(2)), 8);
        chk("cred_blocked", 32'(allow), 0);
        valid = 3'b111;
        #1;
        chk("cred_ch0", 32'(allow), 32'b001);
        push(0);
        tick();
        chk("cred_ch1", 32'(allow), 32'b010);
        push(1);
        tick();
        valid = 3'b100;
        #1;
        chk("cred_still_blocked", 32'(allow), 0);
        rtn = 3'b100;
        tick();
        rtn = 0;
        chk("cred_outs_after_rtn", 32'(outs(2)), 7);
        chk("cred_regrant", 32'(allow), 32'b100);
        push(2);
        tick();
        valid = 0;
        chk("cred_outs_refull", 32'(outs(2)), 8);
        tick();

        // Simultaneous kickoff and return on ch0 at cnt=5
        do_reset();
        set_ch(0, 32'h700, 4'd9);
        valid = 3'b001;
        for (int k = 0; k < 5; k++) begin
            push(0);
            tick();
        end
        chk("sim_outs5", 32'(outs(0)), 5);
        rtn = 3'b001;
        #1;
        chk("sim_allow", 32'(allow), 32'b001);
        push(0);
        tick();
        valid = 0;
        rtn   = 0;
        chk("sim_outs_hold", 32'(outs(0)), 5);
        tick();

        // Underflow error, then reset mid-FULL
        rtn = 3'b010;
        tick();
        rtn = 0;
        chk("err_set", 32'(err), 1);
        chk("err_outs1", 32'(outs(1)), 0);
        tick();
        chk("err_sticky", 32'(err), 1);
        brdy = 0;
        set_ch(0, 32'h800, 4'd2);
        valid = 3'b001;
        tick();
        valid = 0;
        chk("mid_full_valid", 32'(bvalid), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(bvalid), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_outs", 32'(outs_bus), 0);
        chk("mid_rst_allow", 32'(allow), 0);
        tick();
        rst_n = 1;
        brdy  = 1;
        tick();
        tick();
        chk("queue_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
